data_bus_responder: RTL and testbench
=====================================

# data_bus_responder

Memory-side responder for the pipelined MIPS core's MEM stage. It accepts the EX/MEM read/write request (Address, WriteData, MemRead, MemWrite) and serves it from a word RAM or from two memory-mapped I/O registers (PortIn, PortOut). Access latency is configurable through wait states. It returns registered ReadData with a one-cycle Ready pulse, and drives Stall back to the pipeline hazard logic while a request is outstanding.

## Interface
- MEMORY_DEPTH, 256, number of 32-bit words in the data RAM
- WAIT_STATES, 2, extra cycles per access (0–15)
- DATA_BASE, 32'h10010000, byte address of RAM word 0
- MMIO_BASE, 32'hFFFF0000, byte address of the MMIO window
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Address  in  32  byte address from EX/MEM ALU result
- WriteData  in  32  store data
- MemRead  in  1  read request
- MemWrite  in  1  write request
- PortIn  in  8  external input pins, asynchronous to clk
- ReadData  out  32  registered read data, valid while Ready=1
- Ready  out  1  one-cycle completion pulse
- Stall  out  1  (MemRead|MemWrite) & !Ready; forced 0 while reset is low
- AddrError  out  1  pulses with Ready on a faulted access
- PortOut  out  32  MMIO output register

## Operation
- **States:** IDLE, WAIT, RESP.
- **IDLE**
  - A request is MemRead|MemWrite.
  - On a request, capture Address, WriteData and the read/write type.
  - If WAIT_STATES=0, go to RESP. Otherwise load cnt=WAIT_STATES-1 and go to WAIT.
- **WAIT**
  - If cnt=0, go to RESP. Otherwise decrement cnt.
  - The inputs are ignored; the captured copy is used.
- **Entering RESP:** on the edge into RESP, commit the write or register the read data into ReadData.
- **RESP:** Ready=1 and AddrError is valid. Unconditionally go to IDLE.
- **Requester rule:** hold the request stable until Ready. A request still asserted in the cycle after RESP is a new transaction.
- **Address decode** (captured address):
  - **RAM:** DATA_BASE ≤ A < DATA_BASE+4·MEMORY_DEPTH and A[1:0]=0. Word index = (A−DATA_BASE)>>2.
  - **MMIO+0x0:** read returns {24'b0, PortIn_sync}. A write is ignored with no error.
  - **MMIO+0x4:** read returns PortOut. A write loads PortOut.
  - **Any other address, or A[1:0]≠0:** AddrError=1, ReadData=0, no state change.
- **MemRead & MemWrite both set:** treated as a fault. AddrError=1, ReadData=0, no write.
- **Write completion:** a completed write returns ReadData=0.
- **PortIn synchronization:** PortIn passes through a 2-flop synchronizer. PortIn_sync lags the pins by 2 cycles.
- **RAM:** synchronous write, content not reset.

## Timing
- **Reset values:** ReadData=0, Ready=0, AddrError=0, PortOut=0, Stall=0, state=IDLE, cnt=0, synchronizer flops=0.
- **Latency:** request first seen in IDLE at cycle N gives Ready in cycle N+1+WAIT_STATES. Stall is high from cycle N to N+WAIT_STATES inclusive.
- **Throughput:** one transaction per WAIT_STATES+2 cycles. A mandatory IDLE cycle follows each RESP.
- **Reset mid-transaction:** return to IDLE immediately. An uncommitted write is discarded, and a write already committed stays. Ready is not emitted.
- **Ready and AddrError:** never high for more than one consecutive cycle.
- **Counter:** cnt is 4 bits and never wraps; WAIT exits at 0.

## Structure
- **Shared package:** state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), MMIO offsets PORTIN_OFS=0 and PORTOUT_OFS=4, and DATA_BASE/MMIO_BASE defaults.
- **Sub-module bus_addr_decode** (combinational): address plus request type in; is_ram, is_portin, is_portout, fault and word_index out.
- **RAM array** is inferred inside data_bus_responder.

## Test plan
- **RAM write then read:** WAIT_STATES=2. Write 32'hDEADBEEF to 32'h10010008, then read it back. Each access gives Ready 3 cycles after the request, and the read returns 32'hDEADBEEF with AddrError=0.
- **Zero wait states:** WAIT_STATES=0. Back-to-back reads of 32'h10010000 and 32'h10010004 give Ready in cycle N+1, then Ready again in cycle N+3, and Stall=1 only in request cycles without Ready.
- **MMIO:**
  - Write 32'h0000_00A5 to 32'hFFFF0004: PortOut=32'hA5 after the Ready edge.
  - PortIn=8'h3C held ≥2 cycles, then read 32'hFFFF0000: ReadData=32'h0000003C.
- **Faults:** each of the following gives AddrError=1 with Ready and ReadData=0, and RAM and PortOut unchanged:
  - read of 32'h10010002 (misaligned);
  - write to 32'h10010400 with MEMORY_DEPTH=256 (out of range);
  - MemRead=MemWrite=1.
- **Reset mid-transaction:** assert reset low during WAIT of a write of 32'h12345678 to 32'h10010010. No Ready is produced, all outputs return to reset values, and a later read of 32'h10010010 returns its prior content.

Source files
------------

// File: rtl/data_bus_responder_pkg.sv
// Shared types and constants for the MEM-stage data bus responder.
package data_bus_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] PORTIN_OFS    = 32'h0000_0000;
  localparam logic [31:0] PORTOUT_OFS   = 32'h0000_0004;
  localparam logic [31:0] DEF_DATA_BASE = 32'h1001_0000;
  localparam logic [31:0] DEF_MMIO_BASE = 32'hFFFF_0000;

endpackage

// File: rtl/data_bus_responder_if.sv
// Request/response bundle between the EX/MEM stage and the data responder.
interface data_bus_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;
  logic        addr_error;

  modport master (output addr, wdata, mem_read, mem_write,
                  input  rdata, ready, stall, addr_error);
  modport slave  (input  addr, wdata, mem_read, mem_write,
                  output rdata, ready, stall, addr_error);
endinterface

// File: rtl/data_bus_responder_bus_addr_decode.sv
// Combinational address decode: RAM window, two MMIO registers, fault.
module bus_addr_decode
  import data_bus_responder_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 256,
  parameter logic [31:0] DATA_BASE    = DEF_DATA_BASE,
  parameter logic [31:0] MMIO_BASE    = DEF_MMIO_BASE,
  localparam int         IDX_W        = $clog2(MEMORY_DEPTH)
) (
  input  logic [31:0]      i_addr,
  input  logic             i_rd,
  input  logic             i_wr,
  output logic             o_is_ram,
  output logic             o_is_portin,
  output logic             o_is_portout,
  output logic             o_fault,
  output logic [IDX_W-1:0] o_word_index
);
  localparam logic [31:0] RAM_BYTES = 32'(4 * MEMORY_DEPTH);

  logic [31:0] w_ofs;
  logic        w_aligned, w_hit_ram, w_hit_in, w_hit_out;

  // Offset compare avoids overflow if the RAM window touches the top of memory.
  assign w_ofs     = i_addr - DATA_BASE;
  assign w_aligned = (i_addr[1:0] == 2'b00);
  assign w_hit_ram = (i_addr >= DATA_BASE) && (w_ofs < RAM_BYTES);
  assign w_hit_in  = (i_addr == MMIO_BASE + PORTIN_OFS);
  assign w_hit_out = (i_addr == MMIO_BASE + PORTOUT_OFS);

  // Simultaneous read+write is a fault regardless of address.
  assign o_fault      = (i_rd & i_wr) | ~w_aligned | ~(w_hit_ram | w_hit_in | w_hit_out);
  assign o_is_ram     = w_hit_ram & ~o_fault;
  assign o_is_portin  = w_hit_in  & ~o_fault;
  assign o_is_portout = w_hit_out & ~o_fault;
  assign o_word_index = w_ofs[IDX_W+1:2];
endmodule

// File: rtl/data_bus_responder.sv
// MEM-stage responder: word RAM plus PortIn/PortOut MMIO, with wait states.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 256,
  parameter int          WAIT_STATES  = 2,
  parameter logic [31:0] DATA_BASE    = DEF_DATA_BASE,
  parameter logic [31:0] MMIO_BASE    = DEF_MMIO_BASE
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [7:0]           i_port_in,
  output logic [31:0]          o_port_out,
  data_bus_responder_if.slave  bus
);
  localparam int         IDX_W    = $clog2(MEMORY_DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_addr, r_wdata, r_rdata, r_port_out;
  logic        r_rd, r_wr, r_fault;
  logic [7:0]  r_sync1, r_sync2;
  logic [31:0] r_mem [MEMORY_DEPTH];

  logic             w_req_in, w_commit;
  logic [31:0]      w_addr, w_wdata;
  logic             w_rd, w_wr;
  logic             w_is_ram, w_is_portin, w_is_portout, w_fault;
  logic [IDX_W-1:0] w_idx;

  assign w_req_in = bus.mem_read | bus.mem_write;

  // In IDLE the live request is decoded so a zero-wait access can commit on
  // the same edge that captures it; later the captured copy is used.
  assign w_addr  = (r_state == ST_IDLE) ? bus.addr      : r_addr;
  assign w_wdata = (r_state == ST_IDLE) ? bus.wdata     : r_wdata;
  assign w_rd    = (r_state == ST_IDLE) ? bus.mem_read  : r_rd;
  assign w_wr    = (r_state == ST_IDLE) ? bus.mem_write : r_wr;

  bus_addr_decode #(
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .DATA_BASE   (DATA_BASE),
    .MMIO_BASE   (MMIO_BASE)
  ) u_dec (
    .i_addr      (w_addr),
    .i_rd        (w_rd),
    .i_wr        (w_wr),
    .o_is_ram    (w_is_ram),
    .o_is_portin (w_is_portin),
    .o_is_portout(w_is_portout),
    .o_fault     (w_fault),
    .o_word_index(w_idx)
  );

  // Side effects happen only on the edge into RESP; gating with reset keeps
  // the un-reset RAM from being written while reset is held.
  assign w_commit = i_rst_n && (r_state != ST_RESP) && (w_next == ST_RESP);

  // State register and wait counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: IDLE -> [WAIT] -> RESP -> IDLE.
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      ST_IDLE: if (w_req_in) begin
        if (WAIT_STATES == 0) w_next = ST_RESP;
        else begin
          w_next    = ST_WAIT;
          w_cnt_nxt = CNT_LOAD;
        end
      end
      ST_WAIT: if (r_cnt == 4'd0) w_next = ST_RESP;
               else w_cnt_nxt = r_cnt - 4'd1;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Capture the request when it is first seen in IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else if (r_state == ST_IDLE && w_req_in) begin
      r_addr  <= bus.addr;
      r_wdata <= bus.wdata;
      r_rd    <= bus.mem_read;
      r_wr    <= bus.mem_write;
    end
  end

  // Two-flop synchronizer for the external input pins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_port_in;
      r_sync2 <= r_sync1;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (w_commit && w_is_ram && w_wr) r_mem[w_idx] <= w_wdata;
  end

  // Response data, fault flag and PortOut update at commit; writes and faults read as 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata    <= '0;
      r_fault    <= 1'b0;
      r_port_out <= '0;
    end else if (w_commit) begin
      r_fault <= w_fault;
      r_rdata <= '0;
      if (w_rd) begin
        if (w_is_ram)          r_rdata <= r_mem[w_idx];
        else if (w_is_portin)  r_rdata <= {24'b0, r_sync2};
        else if (w_is_portout) r_rdata <= r_port_out;
      end
      if (w_wr && w_is_portout) r_port_out <= w_wdata;
    end
  end

  assign bus.ready      = (r_state == ST_RESP);
  assign bus.addr_error = bus.ready & r_fault;
  assign bus.rdata      = r_rdata;
  assign bus.stall      = i_rst_n & w_req_in & ~bus.ready;
  assign o_port_out     = r_port_out;
endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench: instance 0 uses 2 wait states, instance 1 uses none.
module tb_data_bus_responder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] port_in = 8'h00;
  int checks = 0;
  int failures = 0;

  logic        drv_rd [2];
  logic        drv_wr [2];
  logic [31:0] drv_addr [2];
  logic [31:0] drv_wdata [2];
  logic        rdy_o [2];
  logic        stall_o [2];
  logic        err_o [2];
  logic [31:0] rdata_o [2];
  logic [31:0] pout_o [2];

  always #5 clk = ~clk;

  data_bus_responder_if bus_a ();
  data_bus_responder_if bus_b ();

  assign bus_a.mem_read  = drv_rd[0];
  assign bus_a.mem_write = drv_wr[0];
  assign bus_a.addr      = drv_addr[0];
  assign bus_a.wdata     = drv_wdata[0];
  assign bus_b.mem_read  = drv_rd[1];
  assign bus_b.mem_write = drv_wr[1];
  assign bus_b.addr      = drv_addr[1];
  assign bus_b.wdata     = drv_wdata[1];
  assign rdy_o[0]   = bus_a.ready;
  assign rdy_o[1]   = bus_b.ready;
  assign stall_o[0] = bus_a.stall;
  assign stall_o[1] = bus_b.stall;
  assign err_o[0]   = bus_a.addr_error;
  assign err_o[1]   = bus_b.addr_error;
  assign rdata_o[0] = bus_a.rdata;
  assign rdata_o[1] = bus_b.rdata;

  data_bus_responder #(.MEMORY_DEPTH(256), .WAIT_STATES(2)) u_ws2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_port_in(port_in), .o_port_out(pout_o[0]), .bus(bus_a));
  data_bus_responder #(.MEMORY_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_port_in(port_in), .o_port_out(pout_o[1]), .bus(bus_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction from the IDLE cycle through the trailing IDLE cycle.
  task automatic xact(input int s, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                      input string tag);
    int ws = (s == 0) ? 2 : 0;
    drv_rd[s] = rd; drv_wr[s] = wr; drv_addr[s] = a; drv_wdata[s] = d;
    #1;
    for (int c = 0; c <= ws; c++) begin
      if (c != 0) tick();
      chk({tag, "/busy_ready"}, rdy_o[s], 0);
      chk({tag, "/busy_stall"}, stall_o[s], 1);
    end
    tick();
    chk({tag, "/ready"}, rdy_o[s], 1);
    chk({tag, "/stall_at_ready"}, stall_o[s], 0);
    chk({tag, "/addr_error"}, err_o[s], exp_err);
    chk({tag, "/rdata"}, rdata_o[s], exp_rd);
    drv_rd[s] = 1'b0; drv_wr[s] = 1'b0;
    tick();
    chk({tag, "/idle_ready"}, rdy_o[s], 0);
    chk({tag, "/idle_err"}, err_o[s], 0);
    chk({tag, "/idle_stall"}, stall_o[s], 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      drv_rd[i] = 1'b0; drv_wr[i] = 1'b0; drv_addr[i] = '0; drv_wdata[i] = '0;
    end
    // Reset values, including Stall forced low with a request present.
    drv_rd[0] = 1'b1; drv_addr[0] = 32'h1001_0000;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      chk("reset/ready", rdy_o[i], 0);
      chk("reset/err", err_o[i], 0);
      chk("reset/rdata", rdata_o[i], 0);
      chk("reset/port_out", pout_o[i], 0);
      chk("reset/stall", stall_o[i], 0);
    end
    drv_rd[0] = 1'b0;
    rst_n = 1'b1;
    tick();

    // RAM write then read, 2 wait states.
    xact(0, 0, 1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0, 0, "ws2_wr");
    xact(0, 1, 0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 0, "ws2_rd");
    xact(0, 0, 1, 32'h1001_0000, 32'hCAFE_F00D, 32'h0, 0, "ws2_wr_w0");
    xact(0, 0, 1, 32'h1001_03FC, 32'h0BAD_C0DE, 32'h0, 0, "ws2_wr_last");
    xact(0, 1, 0, 32'h1001_03FC, 32'h0, 32'h0BAD_C0DE, 0, "ws2_rd_last");

    // Zero wait states, back-to-back reads.
    xact(1, 0, 1, 32'h1001_0000, 32'h1111_1111, 32'h0, 0, "ws0_wr0");
    xact(1, 0, 1, 32'h1001_0004, 32'h2222_2222, 32'h0, 0, "ws0_wr1");
    xact(1, 1, 0, 32'h1001_0000, 32'h0, 32'h1111_1111, 0, "ws0_rd0");
    xact(1, 1, 0, 32'h1001_0004, 32'h0, 32'h2222_2222, 0, "ws0_rd1");

    // MMIO.
    xact(0, 0, 1, 32'hFFFF_0004, 32'h0000_00A5, 32'h0, 0, "mmio_wr_out");
    chk("mmio/port_out", pout_o[0], 32'h0000_00A5);
    xact(0, 1, 0, 32'hFFFF_0004, 32'h0, 32'h0000_00A5, 0, "mmio_rd_out");
    port_in = 8'h3C;
    tick(); tick(); tick();
    xact(0, 1, 0, 32'hFFFF_0000, 32'h0, 32'h0000_003C, 0, "mmio_rd_in");
    xact(0, 0, 1, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0, 0, "mmio_wr_in");
    chk("mmio/port_out_kept", pout_o[0], 32'h0000_00A5);

    // Faults.
    xact(0, 1, 0, 32'h1001_0002, 32'h0, 32'h0, 1, "flt_misalign");
    xact(0, 0, 1, 32'h1001_0400, 32'h7777_7777, 32'h0, 1, "flt_range");
    xact(0, 1, 0, 32'h1000_FFFC, 32'h0, 32'h0, 1, "flt_below");
    xact(0, 1, 1, 32'h1001_0008, 32'h5555_5555, 32'h0, 1, "flt_rdwr_ram");
    xact(0, 1, 1, 32'hFFFF_0004, 32'h0000_0077, 32'h0, 1, "flt_rdwr_mmio");
    chk("flt/port_out_kept", pout_o[0], 32'h0000_00A5);
    xact(0, 1, 0, 32'h1001_0000, 32'h0, 32'hCAFE_F00D, 0, "flt_chk_w0");
    xact(0, 1, 0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 0, "flt_chk_w2");

    // Reset during WAIT of a write.
    xact(0, 0, 1, 32'h1001_0010, 32'h55AA_55AA, 32'h0, 0, "rst_prior_wr");
    xact(0, 1, 0, 32'h1001_0010, 32'h0, 32'h55AA_55AA, 0, "rst_prior_rd");
    drv_wr[0] = 1'b1; drv_addr[0] = 32'h1001_0010; drv_wdata[0] = 32'h1234_5678;
    #1;
    chk("rstmid/stall_req", stall_o[0], 1);
    tick();
    rst_n = 1'b0;
    drv_wr[0] = 1'b0;
    #1;
    chk("rstmid/ready", rdy_o[0], 0);
    chk("rstmid/err", err_o[0], 0);
    chk("rstmid/rdata", rdata_o[0], 0);
    chk("rstmid/port_out", pout_o[0], 0);
    chk("rstmid/stall", stall_o[0], 0);
    tick();
    chk("rstmid/ready_hold", rdy_o[0], 0);
    tick();
    chk("rstmid/ready_hold2", rdy_o[0], 0);
    rst_n = 1'b1;
    tick();
    chk("rstmid/ready_after", rdy_o[0], 0);
    xact(0, 1, 0, 32'h1001_0010, 32'h0, 32'h55AA_55AA, 0, "rst_after_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
